full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_fa_cell.sv | 16 +
 rtl/full_adder.sv | 49 ++++
 tb/tb_full_adder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/full_adder_fa_cell.sv
// 1-bit full adder cell; purely combinational, chained by full_adder into a ripple carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic co
);

  logic p;

  assign p   = a ^ b;
  assign sum = p ^ cin;
  assign co  = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with one registered output stage and a valid strobe.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;
  logic             vld_pipe;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (s_comb[i]),
      .co  (c[i+1])
    );
  end

  // Result holds across idle cycles; only the valid strobe drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      co       <= 1'b0;
      vld_pipe <= 1'b0;
    end else begin
      vld_pipe <= in_valid;
      if (in_valid) begin
        sum <= s_comb;
        co  <= c[WIDTH];
      end
    end
  end

  assign out_valid = vld_pipe;

endmodule

// File: tb/tb_full_adder.sv
// Directed-vector bench for full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       s1, co1, ov1;

  logic       v4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] s4;
  logic       co4, ov4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .sum(s1), .co(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .sum(s4), .co(co4), .out_valid(ov4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    #2;
    checks++;
    if ({co1, s1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_w1_async: got %b want 000", {co1, s1, ov1});
    end
    tick();
    tick();
    checks++;
    if ({co1, s1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_w1_clocked: got %b want 000", {co1, s1, ov1});
    end
    checks++;
    if ({co4, s4, ov4} !== 6'b0) begin
      errors++;
      $display("FAIL reset_w4_clocked: got co=%b sum=%h ov=%b want 0/0/0", co4, s4, ov4);
    end
    v1 = 1'b0; v4 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] vec;
      vec = 3'(i);
      {a1, b1, cin1} = vec;
      v1 = 1'b1;
      tick();
      checks++;
      if ({co1, s1} !== exp_tab[i] || ov1 !== 1'b1) begin
        errors++;
        $display("FAIL truth_%0d: got co,sum=%b ov=%b want %b ov=1", i, {co1, s1}, ov1, exp_tab[i]);
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_width4();
    logic [3:0] ta [4] = '{4'hF, 4'hF, 4'h0, 4'h5};
    logic [3:0] tb [4] = '{4'h1, 4'hF, 4'h0, 4'h3};
    logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] te [4] = '{5'h10, 5'h1F, 5'h00, 5'h09};
    for (int i = 0; i < 4; i++) begin
      a4 = ta[i]; b4 = tb[i]; cin4 = tc[i]; v4 = 1'b1;
      tick();
      checks++;
      if ({co4, s4} !== te[i] || ov4 !== 1'b1) begin
        errors++;
        $display("FAIL w4_vec%0d: got co=%b sum=%h ov=%b want co=%b sum=%h ov=1",
                 i, co4, s4, ov4, te[i][4], te[i][3:0]);
      end
    end
    v4 = 1'b0;
    tick();
    checks++;
    if ({co4, s4} !== 5'h09 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL w4_idle_hold: got co=%b sum=%h ov=%b want co=0 sum=9 ov=0", co4, s4, ov4);
    end
  endtask

  task automatic test_hold();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
    tick();
    checks++;
    if ({co1, s1, ov1} !== 3'b111) begin
      errors++;
      $display("FAIL hold_load: got %b want 111", {co1, s1, ov1});
    end
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({co1, s1, ov1} !== 3'b110) begin
        errors++;
        $display("FAIL hold_idle%0d: got %b want 110", i, {co1, s1, ov1});
      end
    end
  endtask

  task automatic test_async_reset();
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b1;
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0; v4 = 1'b1;
    tick();
    checks++;
    if ({co1, s1, ov1} !== 3'b011 || ov4 !== 1'b1) begin
      errors++;
      $display("FAIL areset_preload: got w1=%b ov4=%b want 011 ov4=1", {co1, s1, ov1}, ov4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({co1, s1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL areset_w1_immediate: got %b want 000", {co1, s1, ov1});
    end
    checks++;
    if ({co4, s4, ov4} !== 6'b0) begin
      errors++;
      $display("FAIL areset_w4_immediate: got co=%b sum=%h ov=%b want 0/0/0", co4, s4, ov4);
    end
    tick();
    v1 = 1'b0; v4 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_post_reset();
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1; v1 = 1'b1;
    a4 = 4'hA; b4 = 4'h5; cin4 = 1'b1; v4 = 1'b1;
    tick();
    checks++;
    if ({co1, s1, ov1} !== 3'b011) begin
      errors++;
      $display("FAIL post_reset_w1: got co,sum,ov=%b want 011", {co1, s1, ov1});
    end
    checks++;
    if ({co4, s4} !== 5'h10 || ov4 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_w4: got co=%b sum=%h ov=%b want co=1 sum=0 ov=1", co4, s4, ov4);
    end
    v1 = 1'b0; v4 = 1'b0;
    tick();
    checks++;
    if (ov1 !== 1'b0 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_valid_drop: got ov1=%b ov4=%b want 0 0", ov1, ov4);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_width4();
    test_hold();
    test_async_reset();
    test_post_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
